mux5_arbiter: RTL and testbench
===============================

MUX5_ARBITER -- requirements
Module: mux5_arbiter

Interface
REQ-001 Parameter: WIDTH, 5, bit width of both requester data paths and the shared output path.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_a  input  1  requester A has valid data_a; held until gnt_a seen.
REQ-005 data_a  input  WIDTH  requester A payload.
REQ-006 req_b  input  1  requester B has valid data_b; held until gnt_b seen.
REQ-007 data_b  input  WIDTH  requester B payload.
REQ-008 gnt_a  output  1  combinational; high = data_a captured at this rising edge.
REQ-009 gnt_b  output  1  combinational; high = data_b captured at this rising edge.
REQ-010 out_valid  output  1  registered; shared output buffer holds a transfer.
REQ-011 out_data  output  WIDTH  registered; buffered payload.
REQ-012 out_ready  input  1  consumer accepts out_data this edge when out_valid=1.
REQ-013 sel  output  1  registered mux control for the shared path: 0 = buffer holds A, 1 = holds B.

Function
REQ-014 FSM states SHALL be EMPTY, FULL_A, FULL_B; out_valid=1 exactly in FULL_A/FULL_B; sel=1 exactly in FULL_B.
REQ-015 Slot open SHALL be defined as (state==EMPTY) or (out_valid and out_ready).
REQ-016 Arbitration SHALL occur only when slot open; at most one of gnt_a/gnt_b high in any cycle.
REQ-017 Only req_a high and slot open: gnt_a=1; next state FULL_A, out_data<=data_a.
REQ-018 Only req_b high and slot open: gnt_b=1; next state FULL_B, out_data<=data_b.
REQ-019 Both high and slot open: grant the requester not granted last (round-robin); last_gnt flag updates on every grant.
REQ-020 Slot not open: gnt_a=gnt_b=0; state, out_data, sel held unchanged.
REQ-021 Slot open, no request: if FULL and out_ready, next state EMPTY; out_data holds last value.
REQ-022 Latency: grant in cycle N -> out_valid=1 with that payload in cycle N+1.
REQ-023 Throughput: with out_ready held 1 and requests pending, one grant per cycle (drain and refill on same edge).
REQ-024 out_data/out_valid/sel SHALL not change while out_valid=1 and out_ready=0.
REQ-025 A requester with req held high SHALL be granted within 2 slot-open cycles (no starvation).
REQ-026 req deasserted before grant SHALL withdraw the request with no side effect.
REQ-027 Payload SHALL pass unmodified, all WIDTH bits, no truncation or extension.

Reset
REQ-028 rst_n low SHALL immediately force state EMPTY, out_valid=0, out_data=0, sel=0, last_gnt=B (A wins first tie).
REQ-029 gnt_a/gnt_b SHALL be 0 while rst_n low regardless of requests.
REQ-030 Reset mid-transfer SHALL discard buffered payload; no transfer resumes after release.
REQ-031 First grant possible on first rising edge with rst_n high.

Verification
REQ-032 Reset, req_a=1 data_a=5'b11111, out_ready=1 -> gnt_a=1 in cycle 0; cycle 1 out_valid=1, out_data=5'b11111, sel=0.
REQ-033 req_a=req_b=1 continuous, data_a=5'd3, data_b=5'd28, out_ready=1 -> grants alternate A,B,A,B; out_data 3,28,3,28; sel 0,1,0,1.
REQ-034 Buffer FULL_B with 5'd9, out_ready=0 for 4 cycles, req_a=1 -> no gnt_a, out_data stays 9, sel=1; out_ready=1 -> gnt_a same cycle, next out_data=data_a, sel=0.
REQ-035 Only req_b=1 data_b incrementing 0..31 with out_ready=1 -> 32 consecutive grants, out_data 0..31, wraps 31->0 correctly.
REQ-036 rst_n pulled low while FULL_A and req_b=1 -> out_valid=0, out_data=0, gnt_b=0 immediately (no clock edge); after release, req_b granted on next edge.

Source files
------------

// File: rtl/mux5_arbiter.sv
// Two-requester round-robin arbiter feeding a single registered output buffer.
// Grants are combinational; the buffer drains and refills on the same edge.
module mux5_arbiter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL_A = 2'd1,
        FULL_B = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] out_data_r;
    logic [WIDTH-1:0] data_next_s;
    logic             out_valid_r;
    logic             out_valid_next_s;
    logic             sel_r;
    logic             sel_next_s;
    logic             last_gnt_b_r;
    logic             last_gnt_b_next_s;
    logic             slot_open_s;
    logic             gnt_a_s;
    logic             gnt_b_s;

    // Slot-open detection and round-robin grant selection (gated off during reset).
    always_comb begin
        slot_open_s = 1'b0;
        gnt_a_s     = 1'b0;
        gnt_b_s     = 1'b0;
        if (state_r == EMPTY) begin
            slot_open_s = 1'b1;
        end else if (out_valid_r && out_ready) begin
            slot_open_s = 1'b1;
        end else begin
            slot_open_s = 1'b0;
        end
        if (rst_n && slot_open_s) begin
            if (req_a && req_b) begin
                if (last_gnt_b_r) begin
                    gnt_a_s = 1'b1;
                end else begin
                    gnt_b_s = 1'b1;
                end
            end else if (req_a) begin
                gnt_a_s = 1'b1;
            end else if (req_b) begin
                gnt_b_s = 1'b1;
            end else begin
                gnt_a_s = 1'b0;
                gnt_b_s = 1'b0;
            end
        end else begin
            gnt_a_s = 1'b0;
            gnt_b_s = 1'b0;
        end
    end

    // Next-state, next-payload and next-output decode.
    always_comb begin
        state_next_s      = state_r;
        data_next_s       = out_data_r;
        last_gnt_b_next_s = last_gnt_b_r;
        out_valid_next_s  = out_valid_r;
        sel_next_s        = sel_r;
        if (gnt_a_s) begin
            state_next_s      = FULL_A;
            data_next_s       = data_a;
            last_gnt_b_next_s = 1'b0;
        end else if (gnt_b_s) begin
            state_next_s      = FULL_B;
            data_next_s       = data_b;
            last_gnt_b_next_s = 1'b1;
        end else if (slot_open_s) begin
            state_next_s = EMPTY;
        end else begin
            state_next_s = state_r;
        end
        case (state_next_s)
            FULL_A: begin
                out_valid_next_s = 1'b1;
                sel_next_s       = 1'b0;
            end
            FULL_B: begin
                out_valid_next_s = 1'b1;
                sel_next_s       = 1'b1;
            end
            default: begin
                out_valid_next_s = 1'b0;
                sel_next_s       = 1'b0;
            end
        endcase
    end

    // State and output registers; reset leaves B as last winner so A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= EMPTY;
            out_data_r   <= {WIDTH{1'b0}};
            out_valid_r  <= 1'b0;
            sel_r        <= 1'b0;
            last_gnt_b_r <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            out_data_r   <= data_next_s;
            out_valid_r  <= out_valid_next_s;
            sel_r        <= sel_next_s;
            last_gnt_b_r <= last_gnt_b_next_s;
        end
    end

    assign gnt_a     = gnt_a_s;
    assign gnt_b     = gnt_b_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign sel       = sel_r;

endmodule

// File: tb/tb_mux5_arbiter.sv
// Scoreboard bench for mux5_arbiter: each grant queues {sel,payload}; the buffer
// contents are checked against the queue front every cycle until consumed.
module tb_mux5_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req_a;
    logic [4:0] data_a;
    logic       req_b;
    logic [4:0] data_b;
    logic       gnt_a;
    logic       gnt_b;
    logic       out_valid;
    logic [4:0] out_data;
    logic       out_ready;
    logic       sel;

    logic [5:0] sb[$];
    logic       m_last_b;
    logic       seen_ga;
    logic       seen_gb;
    int         n_cmp;
    int         n_fail;

    mux5_arbiter #(.WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .data_a(data_a),
        .req_b(req_b), .data_b(data_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .sel(sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus just after a falling edge, check, then advance.
    task automatic drive(input logic ra, input logic [4:0] da, input logic rb,
                         input logic [4:0] db, input logic rdy);
        logic       exp_ga;
        logic       exp_gb;
        logic       slot;
        logic [5:0] fr;
        req_a = ra; data_a = da; req_b = rb; data_b = db; out_ready = rdy;
        #1;
        n_cmp++;
        if (out_valid !== (sb.size() != 0)) begin
            n_fail++;
            $display("FAIL out_valid: got %b want %b", out_valid, (sb.size() != 0));
        end
        if (sb.size() != 0) begin
            fr = sb[0];
            n_cmp++;
            if ({sel, out_data} !== fr) begin
                n_fail++;
                $display("FAIL buffer: got sel=%b data=%0d want sel=%b data=%0d",
                         sel, out_data, fr[5], fr[4:0]);
            end
        end
        slot   = (sb.size() == 0) || rdy;
        exp_ga = 1'b0;
        exp_gb = 1'b0;
        if (slot) begin
            if (ra && rb) begin
                exp_ga = m_last_b;
                exp_gb = ~m_last_b;
            end else begin
                exp_ga = ra;
                exp_gb = rb;
            end
        end
        n_cmp++;
        if ({gnt_a, gnt_b} !== {exp_ga, exp_gb}) begin
            n_fail++;
            $display("FAIL grant: got a=%b b=%b want a=%b b=%b", gnt_a, gnt_b, exp_ga, exp_gb);
        end
        seen_ga = gnt_a;
        seen_gb = gnt_b;
        if (sb.size() != 0 && rdy) void'(sb.pop_front());
        if (exp_ga) begin
            sb.push_back({1'b0, da});
            m_last_b = 1'b0;
        end else if (exp_gb) begin
            sb.push_back({1'b1, db});
            m_last_b = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0; data_a = 5'd0; data_b = 5'd0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        m_last_b = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_a = 1'b1; req_b = 1'b1; data_a = 5'd7; data_b = 5'd8; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({gnt_a, gnt_b, out_valid, sel, out_data} !== 9'd0) begin
                n_fail++;
                $display("FAIL reset_state: got gnt=%b%b v=%b sel=%b data=%0d want all 0",
                         gnt_a, gnt_b, out_valid, sel, out_data);
            end
        end
        apply_reset();
    endtask

    task automatic test_single_a();
        apply_reset();
        drive(1'b1, 5'b11111, 1'b0, 5'd0, 1'b1);
        n_cmp++;
        if (seen_ga !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant: got gnt_a=%b want 1", seen_ga);
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    endtask

    task automatic test_alternate();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 5'd3, 1'b1, 5'd28, 1'b1);
            n_cmp++;
            if ({seen_ga, seen_gb} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL alternate[%0d]: got a=%b b=%b want %s", i, seen_ga, seen_gb,
                         (i % 2 == 0) ? "A" : "B");
            end
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    endtask

    task automatic test_backpressure();
        apply_reset();
        drive(1'b0, 5'd0, 1'b1, 5'd9, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 5'd17, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 5'd17, 1'b0, 5'd0, 1'b1);
        n_cmp++;
        if (seen_ga !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got gnt_a=%b want 1", seen_ga);
        end
        // Withdrawn request while stalled must leave no trace.
        drive(1'b0, 5'd0, 1'b1, 5'd4, 1'b0);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int grants;
        apply_reset();
        grants = 0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 1'b1, 5'(i), 1'b1);
            if (seen_gb) grants++;
        end
        drive(1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        n_cmp++;
        if (grants !== 32) begin
            n_fail++;
            $display("FAIL b2b_grants: got %0d want 32", grants);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
        req_a = 1'b0; req_b = 1'b1; data_b = 5'd21; out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_data, gnt_b} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b data=%0d gnt_b=%b want 0/0/0",
                     out_valid, out_data, gnt_b);
        end
        sb.delete();
        m_last_b = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 1'b1, 5'd21, 1'b1);
        n_cmp++;
        if (seen_gb !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_grant: got gnt_b=%b want 1", seen_gb);
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        m_last_b = 1'b1;
        seen_ga = 1'b0;
        seen_gb = 1'b0;
        test_reset();
        test_single_a();
        test_alternate();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
